// File: rtl/sca_demux_stream.sv
// One-to-two stream demultiplexer: each accepted input word is steered by SEL into
// a one-entry holding slot on port A or port B, with a per-port delivered-beat counter.
module sca_demux_stream #(
  parameter int SIZE  = 1,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [SIZE-1:0]  IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             SEL,
  output logic [SIZE-1:0]  OUT_A,
  output logic             OUT_A_VALID,
  input  logic             OUT_A_READY,
  output logic [SIZE-1:0]  OUT_B,
  output logic             OUT_B_VALID,
  input  logic             OUT_B_READY,
  output logic [CNT_W-1:0] CNT_A,
  output logic [CNT_W-1:0] CNT_B
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t            state_a, state_a_nxt;
  slot_t            state_b, state_b_nxt;
  logic [SIZE-1:0]  data_a, data_a_nxt;
  logic [SIZE-1:0]  data_b, data_b_nxt;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic             take_a, take_b;
  logic             accept, load_a, load_b;

  assign take_a = (state_a == FULL) & OUT_A_READY;
  assign take_b = (state_b == FULL) & OUT_B_READY;

  // A full slot can still accept when it is being drained in the same cycle.
  assign IN_READY = ~RST & (SEL ? ((state_b == EMPTY) | OUT_B_READY)
                                : ((state_a == EMPTY) | OUT_A_READY));
  assign accept   = IN_VALID & IN_READY;
  assign load_a   = accept & ~SEL;
  assign load_b   = accept & SEL;

  always_comb begin
    state_a_nxt = state_a;
    state_b_nxt = state_b;
    data_a_nxt  = data_a;
    data_b_nxt  = data_b;

    case (state_a)
      EMPTY:   if (load_a) state_a_nxt = FULL;
      FULL:    if (take_a && !load_a) state_a_nxt = EMPTY;
      default: state_a_nxt = EMPTY;
    endcase
    case (state_b)
      EMPTY:   if (load_b) state_b_nxt = FULL;
      FULL:    if (take_b && !load_b) state_b_nxt = EMPTY;
      default: state_b_nxt = EMPTY;
    endcase

    if (load_a) data_a_nxt = IN_DATA;
    if (load_b) data_b_nxt = IN_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_a <= EMPTY;
      state_b <= EMPTY;
      data_a  <= '0;
      data_b  <= '0;
      cnt_a   <= '0;
      cnt_b   <= '0;
    end else begin
      state_a <= state_a_nxt;
      state_b <= state_b_nxt;
      data_a  <= data_a_nxt;
      data_b  <= data_b_nxt;
      if (take_a) cnt_a <= cnt_a + 1'b1;
      if (take_b) cnt_b <= cnt_b + 1'b1;
    end
  end

  assign OUT_A       = data_a;
  assign OUT_B       = data_b;
  assign OUT_A_VALID = (state_a == FULL);
  assign OUT_B_VALID = (state_b == FULL);
  assign CNT_A       = cnt_a;
  assign CNT_B       = cnt_b;

endmodule

// File: tb/tb_sca_demux_stream.sv
// Bench for sca_demux_stream: two instances (8-bit and 2-bit counters) share one stimulus;
// a negedge scoreboard checks every delivered word while tasks check directed scenarios.
module tb_sca_demux_stream;

  localparam int SIZE = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] in_data;
  logic            in_valid, sel, out_a_ready, out_b_ready;
  logic            in_ready, out_a_valid, out_b_valid;
  logic [SIZE-1:0] out_a, out_b;
  logic [7:0]      cnt_a, cnt_b;
  logic            w_in_ready, w_out_a_valid, w_out_b_valid;
  logic [SIZE-1:0] w_out_a, w_out_b;
  logic [1:0]      w_cnt_a, w_cnt_b;

  int checks = 0;
  int passes = 0;
  int exp_cnt_a = 0, exp_cnt_b = 0;
  int pend_a = 0, pend_b = 0;
  bit rst_pend = 1'b0;
  logic [SIZE-1:0] qa[$];
  logic [SIZE-1:0] qb[$];
  logic [SIZE-1:0] e_a, e_b;

  always #5 clk = ~clk;

  sca_demux_stream #(.SIZE(SIZE), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .SEL(sel), .OUT_A(out_a), .OUT_A_VALID(out_a_valid), .OUT_A_READY(out_a_ready),
    .OUT_B(out_b), .OUT_B_VALID(out_b_valid), .OUT_B_READY(out_b_ready),
    .CNT_A(cnt_a), .CNT_B(cnt_b)
  );

  sca_demux_stream #(.SIZE(SIZE), .CNT_W(2)) dutw (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(w_in_ready),
    .SEL(sel), .OUT_A(w_out_a), .OUT_A_VALID(w_out_a_valid), .OUT_A_READY(out_a_ready),
    .OUT_B(w_out_b), .OUT_B_VALID(w_out_b_valid), .OUT_B_READY(out_b_ready),
    .CNT_A(w_cnt_a), .CNT_B(w_cnt_b)
  );

  // Scoreboard: handshakes seen at a negedge complete at the following posedge,
  // so their count effect is committed one negedge later.
  always @(negedge clk) begin
    exp_cnt_a = rst_pend ? 0 : exp_cnt_a + pend_a;
    exp_cnt_b = rst_pend ? 0 : exp_cnt_b + pend_b;
    pend_a = 0;
    pend_b = 0;
    rst_pend = (rst === 1'b1);
    if (rst === 1'b1) begin
      qa.delete();
      qb.delete();
    end else begin
      if (out_a_valid === 1'b1 && out_a_ready === 1'b1) begin
        pend_a = 1;
        checks++;
        if (qa.size() == 0) $display("[TB] FAIL sb_a_unexpected got %h want none", out_a);
        else begin
          e_a = qa.pop_front();
          if (out_a !== e_a || w_out_a !== e_a || w_out_a_valid !== 1'b1)
            $display("[TB] FAIL sb_a_data got %h/%h want %h", out_a, w_out_a, e_a);
          else passes++;
        end
      end
      if (out_b_valid === 1'b1 && out_b_ready === 1'b1) begin
        pend_b = 1;
        checks++;
        if (qb.size() == 0) $display("[TB] FAIL sb_b_unexpected got %h want none", out_b);
        else begin
          e_b = qb.pop_front();
          if (out_b !== e_b || w_out_b !== e_b || w_out_b_valid !== 1'b1)
            $display("[TB] FAIL sb_b_data got %h/%h want %h", out_b, w_out_b, e_b);
          else passes++;
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        if (sel) qb.push_back(in_data);
        else     qa.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = 1'b0;
    out_a_ready = 1'b1; out_b_ready = 1'b1;
    tick(); tick(); sample();
    checks++;
    if ({out_a_valid, out_b_valid, cnt_a, cnt_b, out_a, out_b, in_ready} !== '0)
      $display("[TB] FAIL reset_state got va=%b vb=%b ca=%0d cb=%0d a=%h b=%h rdy=%b want all 0",
               out_a_valid, out_b_valid, cnt_a, cnt_b, out_a, out_b, in_ready);
    else passes++;
    checks++;
    if ({w_cnt_a, w_cnt_b, w_out_a_valid, w_out_b_valid, w_in_ready} !== '0)
      $display("[TB] FAIL reset_state_w got ca=%0d cb=%0d want 0", w_cnt_a, w_cnt_b);
    else passes++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_route_a();
    in_data = 6'b10_0100; sel = 1'b0; in_valid = 1'b1;
    sample();
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL route_a_ready got %b want 1", in_ready);
    else passes++;
    tick();
    in_valid = 1'b0;
    sample();
    checks++;
    if ({out_a, out_a_valid, out_b_valid} !== {6'b10_0100, 1'b1, 1'b0})
      $display("[TB] FAIL route_a_out got a=%b va=%b vb=%b want a=100100 va=1 vb=0",
               out_a, out_a_valid, out_b_valid);
    else passes++;
    tick(); sample();
    checks++;
    if (cnt_a !== 8'd1 || cnt_b !== 8'd0 || w_cnt_a !== 2'd1)
      $display("[TB] FAIL route_a_cnt got ca=%0d cb=%0d wca=%0d want 1 0 1", cnt_a, cnt_b, w_cnt_a);
    else passes++;
  endtask

  task automatic test_route_b();
    tick();
    in_data = 6'b11_0011; sel = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sample();
    checks++;
    if ({out_b, out_b_valid, out_a, out_a_valid} !== {6'b11_0011, 1'b1, 6'b10_0100, 1'b0})
      $display("[TB] FAIL route_b_out got b=%b vb=%b a=%b va=%b want 110011 1 100100 0",
               out_b, out_b_valid, out_a, out_a_valid);
    else passes++;
    tick(); sample();
    checks++;
    if (cnt_b !== 8'd1) $display("[TB] FAIL route_b_cnt got %0d want 1", cnt_b);
    else passes++;
  endtask

  task automatic test_backpressure();
    tick();
    out_a_ready = 1'b0;
    in_data = 6'b10_1100; sel = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 6'b01_0111;
    sample();
    checks++;
    if (out_a !== 6'b10_1100 || out_a_valid !== 1'b1 || in_ready !== 1'b0)
      $display("[TB] FAIL bp_stall got a=%b va=%b rdy=%b want 101100 1 0", out_a, out_a_valid, in_ready);
    else passes++;
    tick(); sample();
    checks++;
    if (out_a !== 6'b10_1100 || in_ready !== 1'b0)
      $display("[TB] FAIL bp_hold got a=%b rdy=%b want 101100 0", out_a, in_ready);
    else passes++;
    tick();
    out_a_ready = 1'b1;
    sample();
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready got %b want 1", in_ready);
    else passes++;
    tick();
    in_valid = 1'b0;
    sample();
    checks++;
    if (out_a !== 6'b01_0111 || out_a_valid !== 1'b1)
      $display("[TB] FAIL bp_second got a=%b va=%b want 010111 1", out_a, out_a_valid);
    else passes++;
    tick(); sample();
    checks++;
    if (cnt_a !== 8'd3 || out_a_valid !== 1'b0 || qa.size() != 0)
      $display("[TB] FAIL bp_cnt got ca=%0d va=%b pending=%0d want 3 0 0", cnt_a, out_a_valid, qa.size());
    else passes++;
  endtask

  task automatic test_independence();
    tick();
    out_a_ready = 1'b0;
    in_data = 6'b11_1000; sel = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 6'b10_1001; sel = 1'b1;
    sample();
    checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL indep_ready got %b want 1", in_ready);
    else passes++;
    tick();
    in_valid = 1'b0;
    sample();
    checks++;
    if ({out_b, out_b_valid, out_a, out_a_valid} !== {6'b10_1001, 1'b1, 6'b11_1000, 1'b1})
      $display("[TB] FAIL indep_out got b=%b vb=%b a=%b va=%b want 101001 1 111000 1",
               out_b, out_b_valid, out_a, out_a_valid);
    else passes++;
    tick();
    out_a_ready = 1'b1;
    tick(); sample();
    checks++;
    if (cnt_a !== 8'd4 || cnt_b !== 8'd2 || cnt_a !== exp_cnt_a[7:0] || cnt_b !== exp_cnt_b[7:0])
      $display("[TB] FAIL indep_cnt got ca=%0d cb=%0d want 4 2", cnt_a, cnt_b);
    else passes++;
  endtask

  task automatic test_streaming();
    int stalls;
    stalls = 0;
    do_reset();
    out_a_ready = 1'b1; out_b_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = SIZE'($urandom_range(0, 63));
      sel = i[0];
      in_valid = 1'b1;
      sample();
      if (in_ready !== 1'b1) stalls++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (stalls != 0) $display("[TB] FAIL stream_ready got %0d stalls want 0", stalls);
    else passes++;
    tick(); sample();
    checks++;
    if (cnt_a !== 8'd10 || cnt_b !== 8'd10 || w_cnt_a !== 2'd2 || w_cnt_b !== 2'd2)
      $display("[TB] FAIL stream_cnt got %0d %0d w %0d %0d want 10 10 w 2 2", cnt_a, cnt_b, w_cnt_a, w_cnt_b);
    else passes++;
    checks++;
    if (qa.size() != 0 || qb.size() != 0)
      $display("[TB] FAIL stream_drain got %0d/%0d pending want 0/0", qa.size(), qb.size());
    else passes++;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    out_a_ready = 1'b1; out_b_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = SIZE'(i + 1);
      sel = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick(); sample();
    checks++;
    if (w_cnt_a !== 2'd1 || cnt_a !== 8'd5)
      $display("[TB] FAIL wrap_cnt got w=%0d n=%0d want 1 5", w_cnt_a, cnt_a);
    else passes++;
    tick();
    out_b_ready = 1'b0;
    in_data = 6'b01_0101; sel = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sample();
    checks++;
    if (out_b_valid !== 1'b1 || out_b !== 6'b01_0101)
      $display("[TB] FAIL wrap_b_full got vb=%b b=%b want 1 010101", out_b_valid, out_b);
    else passes++;
    tick();
    rst = 1'b1;
    sel = 1'b1;
    sample();
    checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL rst_ready got %b want 0", in_ready);
    else passes++;
    tick();
    rst = 1'b0;
    sample();
    checks++;
    if ({out_a_valid, out_b_valid, cnt_a, cnt_b, out_b, w_cnt_a, w_cnt_b, w_out_b_valid} !== '0)
      $display("[TB] FAIL rst_mid got va=%b vb=%b ca=%0d cb=%0d b=%h wca=%0d wcb=%0d want all 0",
               out_a_valid, out_b_valid, cnt_a, cnt_b, out_b, w_cnt_a, w_cnt_b);
    else passes++;
    out_b_ready = 1'b1;
    tick(); tick(); sample();
    checks++;
    if (out_b_valid !== 1'b0 || cnt_b !== 8'd0)
      $display("[TB] FAIL rst_discard got vb=%b cb=%0d want 0 0", out_b_valid, cnt_b);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_route_a();
    test_route_b();
    test_backpressure();
    test_independence();
    test_streaming();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sca_demux_stream.md
Name: sca_demux_stream

Overview:
- Registered, parameter-width 1-to-2 demultiplexer with valid/ready flow control.
- Inverse of the team's scalable 2:1 mux: one input word is steered by SEL to output port A (SEL=0) or port B (SEL=1).
- Each output has a one-entry holding register and a beat counter.
- Sits between a single producer and two consumers on the same datapath width.

Parameters:
- SIZE, 1, data width in bits (same meaning as the mux SIZE).
- CNT_W, 8, width of the per-output delivered-beat counters.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_DATA  input  SIZE  input word.
- IN_VALID  input  1  IN_DATA/SEL valid this cycle.
- IN_READY  output  1  block can accept the input this cycle.
- SEL  input  1  destination: 0 = A, 1 = B; sampled only on an accepted beat.
- OUT_A  output  SIZE  port A data.
- OUT_A_VALID  output  1  port A holds a word.
- OUT_A_READY  input  1  port A consumer takes the word.
- OUT_B  output  SIZE  port B data.
- OUT_B_VALID  output  1  port B holds a word.
- OUT_B_READY  input  1  port B consumer takes the word.
- CNT_A  output  CNT_W  beats delivered on port A.
- CNT_B  output  CNT_W  beats delivered on port B.

Behaviour:
- Reset: RST high at a rising edge forces OUT_A, OUT_B, CNT_A and CNT_B to 0, and OUT_A_VALID and OUT_B_VALID to 0.
  - Any buffered words are discarded; reset mid-transfer loses them silently.
  - While RST is high, IN_READY = 0.
- Per-output slot X (A or B), state EMPTY (X_VALID=0) or FULL (X_VALID=1):
  - EMPTY -> FULL on an input beat steered to X.
  - FULL -> EMPTY on output handshake (X_VALID & X_READY) with no new beat to X.
  - FULL -> FULL on output handshake plus a new beat to X in the same cycle: the register reloads with the new word, so throughput is 1 word/cycle.
  - FULL with no handshake: OUT_X holds its value and X_VALID stays 1; data must not change until taken.
- IN_READY, combinational from SEL and slot state:
  - SEL=0: IN_READY = ~OUT_A_VALID | OUT_A_READY.
  - SEL=1: IN_READY = ~OUT_B_VALID | OUT_B_READY.
  - IN_READY is forced to 0 during RST.
- Accept: the input beat is accepted when IN_VALID & IN_READY.
  - Latency is 1 cycle: the accepted word appears on OUT_X with X_VALID=1 on the next cycle.
  - The non-selected slot is untouched and can still drain independently in the same cycle.
- Unselected output data: holds its last value, never zeroed except by reset.
- IN_VALID=0: SEL and IN_DATA are don't-care and no state changes apart from output drains.
  - The producer must keep IN_DATA and SEL stable while IN_VALID=1 and IN_READY=0.
- Counters: CNT_X increments by 1 on each output handshake of port X and wraps from 2^CNT_W-1 to 0 with no flag. A and B count independently; both may increment in the same cycle.
- Simultaneous events: an input beat to A, a drain of A and a drain of B can all occur in one cycle and all are honoured.
- SIZE=1 is legal; no width truncation occurs anywhere in the data path.

Test Plan:
- Reset, then route: SIZE=6, RST pulse, both READY=1; IN_DATA=6'b10_0100, SEL=0, one beat.
  - Next cycle: OUT_A=6'b10_0100, OUT_A_VALID=1, OUT_B_VALID=0.
  - One cycle after that: CNT_A=1, CNT_B=0.
- Route to B: IN_DATA=6'b11_0011, SEL=1, one beat.
  - Next cycle: OUT_B=6'b11_0011, OUT_B_VALID=1.
  - OUT_A keeps its old value with OUT_A_VALID=0.
- Backpressure: OUT_A_READY=0; send 6'b10_1100 then 6'b01_0111, both SEL=0.
  - First word is held on OUT_A and IN_READY=0 on the second.
  - Raise OUT_A_READY: 6'b10_1100 is delivered, then 6'b01_0111; CNT_A advances by 2, no loss or duplication.
- Independence: OUT_A stalled and full; send 6'b10_1001 with SEL=1.
  - Accepted immediately; OUT_B=6'b10_1001 next cycle while OUT_A is unchanged.
- Streaming: alternating SEL 0/1, 20 beats, READY=1 throughout.
  - IN_READY stays 1 every cycle and order is preserved per port.
  - CNT_A=10, CNT_B=10.
- Wrap and reset mid-run: CNT_W=2; deliver 5 beats to A, so CNT_A=1.
  - Assert RST while OUT_B_VALID=1: next cycle all valids and counts are 0 and the B word is discarded.
